// File: rtl/fir_pkg.sv
// Shared constants and types for the 4-tap FIR deconvolution path.
// The inverse filter relies on H[0]==1 so no division is ever needed.
package fir_pkg;
  localparam int N_TAPS      = 4;
  localparam int DATA_WIDTH  = 16;
  localparam int COEFF_WIDTH = 16;

  typedef logic signed [COEFF_WIDTH-1:0] coef_t;

  localparam coef_t H [0:N_TAPS-1] = '{coef_t'(1), coef_t'(2), coef_t'(3), coef_t'(4)};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic bit h0_is_one();
    return H[0] == coef_t'(1);
  endfunction
endpackage

// File: rtl/fir_history_reg.sv
// Shift register of previously recovered samples xh[1..DEPTH], newest in xh[1].
// Indexed read returns zero for an index outside 1..DEPTH.
module fir_history_reg #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int IW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic [IW-1:0]     idx,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] xh [1:DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j <= DEPTH; j++) xh[j] <= '0;
    end else if (clear) begin
      for (int j = 1; j <= DEPTH; j++) xh[j] <= '0;
    end else if (push) begin
      xh[1] <= din;
      for (int j = 2; j <= DEPTH; j++) xh[j] <= xh[j-1];
    end
  end

  always_comb begin
    dout = '0;
    for (int j = 1; j <= DEPTH; j++) begin
      if (int'(idx) == j) dout = xh[j];
    end
  end
endmodule

// File: rtl/fir_deconv.sv
// Inverse of the FIR h=[1,2,3,4]: x[n] = y[n] - sum_{k>=1} H[k]*x[n-k], mod 2^DATA_W.
// One shared multiplier walks taps 1..N-1 serially, then holds the result for the sink.
module fir_deconv
  import fir_pkg::*;
#(
  parameter int N      = N_TAPS,
  parameter int DATA_W = DATA_WIDTH,
  parameter int COEF_W = COEFF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic              busy
);
  localparam int KW = (N > 2) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (!h0_is_one()) begin : g_h0_check
    $error("fir_deconv: H[0] must be 1 for exact inversion");
  end

  // Products wrap to DATA_W bits; two's complement makes signed/unsigned identical.
  function automatic logic signed [DATA_W-1:0] mac_sub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [COEF_W-1:0] c,
    input logic signed [DATA_W-1:0] x
  );
    logic signed [DATA_W+COEF_W-1:0] p;
    p = c * x;
    return a - $signed(p[DATA_W-1:0]);
  endfunction

  state_t                    state;
  logic signed [DATA_W-1:0]  acc;
  logic        [KW-1:0]      k;
  logic        [DATA_W-1:0]  xh_k;
  logic signed [DATA_W-1:0]  acc_nxt;
  logic                      push;

  assign acc_nxt  = mac_sub(acc, H[k], $signed(xh_k));
  assign push     = (state == MAC) && (k == K_LAST) && !clear;
  assign in_ready = (state == IDLE) && !clear;
  assign busy     = (state != IDLE);

  fir_history_reg #(
    .DEPTH  (N - 1),
    .DATA_W (DATA_W),
    .IW     (KW)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (acc_nxt),
    .idx   (k),
    .dout  (xh_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc   <= $signed(y_in);
            k     <= KW'(1);
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (k == K_LAST) begin
            x_out     <= acc_nxt;
            out_valid <= 1'b1;
            k         <= '0;
            state     <= OUT;
          end else begin
            k <= k + KW'(1);
          end
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_deconv.sv
// Directed bench for fir_deconv: table of {clear, y, expected x} plus handshake,
// clear and asynchronous-reset sequences.
module tb_fir_deconv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] x_out;
  logic        busy;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fir_deconv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .busy      (busy)
  );

  typedef struct {
    logic        clr;
    logic [15:0] y;
    logic [15:0] x;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [15:0] y);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    y_in     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic send(input logic [15:0] y, input logic [15:0] x, input string name);
    int lat;
    out_ready = 1'b1;
    accept(y);
    wait_out(lat);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_x"}, 32'(x_out), 32'(x));
    @(posedge clk);
    #1;
    check({name, "_done"}, 32'({out_valid, busy}), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    y_in     = 16'h00AA;
    #1;
    check("in_ready_during_clear", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    // impulse response of h=[1,2,3,4] deconvolves back to a unit impulse
    tbl[0]  = '{1'b0, 16'd1, 16'd1};
    tbl[1]  = '{1'b0, 16'd2, 16'd0};
    tbl[2]  = '{1'b0, 16'd3, 16'd0};
    tbl[3]  = '{1'b0, 16'd4, 16'd0};
    tbl[4]  = '{1'b0, 16'd0, 16'd0};
    tbl[5]  = '{1'b0, 16'd0, 16'd0};
    // step input: running sums of h
    tbl[6]  = '{1'b0, 16'd1, 16'd1};
    tbl[7]  = '{1'b0, 16'd3, 16'd1};
    tbl[8]  = '{1'b0, 16'd6, 16'd1};
    tbl[9]  = '{1'b0, 16'd10, 16'd1};
    tbl[10] = '{1'b0, 16'd10, 16'd1};
    // wrap-around from zero history: 0x7FFD - 2*0x7FFF = 0x7FFF mod 2^16
    tbl[11] = '{1'b1, 16'h7FFF, 16'h7FFF};
    tbl[12] = '{1'b0, 16'h7FFD, 16'h7FFF};

    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_x_out", 32'(x_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].clr) pulse_clear();
      send(tbl[i].y, tbl[i].x, $sformatf("vec%0d", i));
    end

    // backpressure: result held, nothing else accepted
    pulse_clear();
    out_ready = 1'b0;
    accept(16'd9);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd3);
    in_valid = 1'b1;
    y_in     = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_x_hold", 32'(x_out), 32'd9);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 32'({out_valid, busy}), 32'd0);
    // history now 9,0,0: y = 9*2 + 5 -> x = 5
    send(16'd23, 16'd5, "bp_followup");

    // clear in the second MAC cycle discards the sample
    pulse_clear();
    send(16'd1, 16'd1, "hist_a");
    send(16'd3, 16'd1, "hist_b");
    send(16'd6, 16'd1, "hist_c");
    accept(16'd5);
    @(posedge clk);
    #1;
    check("mac_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_mac_busy", 32'(busy), 32'd0);
    check("clr_mac_valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("clr_no_valid", 32'(out_valid), 32'd0);
    end
    send(16'd7, 16'd7, "post_clear");

    // asynchronous reset while holding a result in OUT
    pulse_clear();
    out_ready = 1'b0;
    accept(16'd3);
    wait_out(lat);
    check("ar_valid_before", 32'(out_valid), 32'd1);
    check("ar_x_before", 32'(x_out), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_x_out", 32'(x_out), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    #7;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(16'd2, 16'd2, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_deconv.md
Name: fir_deconv

Overview:
- Inverse (deconvolution) filter for our fixed 4-tap FIR, h=[1,2,3,4].
- Takes FIR output samples y[n] and recovers the original input x[n] exactly, modulo 2^DATA_WIDTH:
  x[n] = y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3]
- Sits at the receive end of the filtered-sample path, with valid/ready handshakes on both sides.
- Uses a serial single-multiplier MAC controlled by a small FSM.

Parameters:
- N, 4: number of taps; history depth is N-1.
- DATA_WIDTH, 16: width of y_in, x_out, the accumulator and the history registers.
- COEFF_WIDTH, 16: coefficient width. h[0] must equal 1; the other coefficients come from the package.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous history flush plus abort.
- in_valid  input  1  y_in is valid.
- in_ready  output  1  block can accept a sample.
- y_in  input  DATA_WIDTH  filtered sample y[n].
- out_valid  output  1  x_out is valid.
- out_ready  input  1  downstream accepts x_out.
- x_out  output  DATA_WIDTH  recovered sample x[n].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc=0; history xh[1..N-1]=0; tap index k=0.
  - x_out=0, out_valid=0, busy=0.
  - in_ready=1 after release.
- IDLE:
  - in_ready = !clear.
  - On in_valid && in_ready: acc<=y_in, k<=1, go to MAC.
- MAC: runs exactly N-1 cycles. Each cycle:
  - acc <= acc - H[k]*xh[k], truncated to DATA_WIDTH.
  - k++.
  - After k=N-1: x_out<=next acc, out_valid<=1, go to OUT.
  - In the same edge, shift history: xh[1]<=new x, xh[j]<=xh[j-1].
- OUT:
  - Hold x_out and out_valid stable until out_ready.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 in MAC and OUT.
- Latency and throughput:
  - Sample accepted at edge t gives out_valid high after edge t+N-1, i.e. N-1 MAC cycles. For N=4, out_valid rises 3 cycles after acceptance.
  - With out_ready held high, throughput is one sample per N+1 cycles (IDLE + N-1 MAC + OUT).
- Arithmetic:
  - All operations are modulo 2^DATA_WIDTH; products are truncated to the low DATA_WIDTH bits.
  - Signed and unsigned interpretations give identical bits.
  - Inversion is exact because h[0]=1. No saturation, no overflow flag.
- Handshake:
  - x_out must not change while out_valid=1 and out_ready=0.
  - in_ready does not depend on in_valid.
- clear=1 in any state, at the next edge:
  - state<=IDLE, history<=0, acc<=0, out_valid<=0.
  - Any in-flight sample is discarded.
  - In IDLE, a simultaneous in_valid is not accepted, since in_ready=0 while clear=1.
- rst_n asserted mid-MAC or mid-OUT: immediate return to the reset values; the partial result is lost.
- Back-to-back: a new sample cannot be accepted on the same edge that OUT completes; it is accepted in IDLE on the following cycle.

Decomposition:
- Package fir_pkg holds:
  - N_TAPS, DATA_WIDTH, COEFF_WIDTH.
  - Constant coefficient array H[0:N-1]='{1,2,3,4}.
  - state enum {IDLE, MAC, OUT}.
  - The elaboration check H[0]==1.
- One sub-module is natural: fir_history_reg.
  - N-1 deep shift register of DATA_WIDTH words.
  - Has a push and a sync clear.
  - Provides indexed read of xh[k].

Test Plan:
1. Impulse: y_in sequence 1,2,3,4,0,0 with out_ready=1 -> x_out 1,0,0,0,0,0. Each output appears 3 cycles after acceptance.
2. Constant input: y_in 1,3,6,10,10 -> x_out 1,1,1,1,1.
3. Wrap-around: y_in 0x7FFF then 0x7FFD -> x_out 0x7FFF, 0x7FFF, with no saturation.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> x_out stable, in_ready=0 throughout, and no second sample accepted. Release -> transfer occurs, then IDLE.
5. Clear mid-MAC:
   - Accept y_in=5 after history 1,1,1, assert clear in the second MAC cycle -> no out_valid; busy=0 next cycle.
   - Next y_in=7 -> x_out=7, confirming zero history.
6. Async reset: drop rst_n mid-OUT, asynchronously to clk -> out_valid=0 and x_out=0 immediately. After release, y_in=2 -> x_out=2.
